// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock synchronous FIFO with configurable word width and power-of-two
// depth. Provides occupancy count, full/empty flags, programmable
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses
// for rejected requests.
//
// Compile-time option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through: rdata shows the
//                                   head word combinationally, valid = !empty,
//                                   rd pops the shown word.
//                      undefined -> standard mode: an accepted read registers
//                                   the head word into rdata and pulses valid
//                                   for one cycle; rdata holds otherwise.
//
// Parameters:
//   data_width     word width in bits (>=1)
//   fifo_depth     number of entries, power of two, >=2
//   afull_thresh   almost_full  when count >= afull_thresh  (1..fifo_depth)
//   aempty_thresh  almost_empty when count <= aempty_thresh (0..fifo_depth-1)
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   wr / wdata    write request and data
//   rd            read request (pop in FWFT mode)
//   rdata / valid read data and its qualifier
//   full / empty  occupancy flags
//   almost_full / almost_empty  threshold flags
//   count         occupancy 0..fifo_depth
//   overflow      pulse the cycle after a rejected write
//   underflow     pulse the cycle after a rejected read
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int data_width    = 8,
  parameter int fifo_depth    = 8,
  parameter int afull_thresh  = fifo_depth - 2,
  parameter int aempty_thresh = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr,
  input  logic [data_width-1:0]         wdata,
  input  logic                          rd,
  output logic [data_width-1:0]         rdata,
  output logic                          valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int aw = $clog2(fifo_depth);
  localparam int cw = aw + 1;

  localparam logic [cw-1:0] depth_c  = cw'(fifo_depth);
  localparam logic [cw-1:0] afull_c  = cw'(afull_thresh);
  localparam logic [cw-1:0] aempty_c = cw'(aempty_thresh);

  logic [data_width-1:0] mem_r [fifo_depth];
  logic [aw-1:0]         wr_ptr_r;
  logic [aw-1:0]         rd_ptr_r;
  logic [cw-1:0]         count_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Flags derived from the registered count; acceptance uses start-of-cycle flags.
  always_comb begin
    full_s   = (count_r == depth_c);
    empty_s  = (count_r == {cw{1'b0}});
    wr_acc_s = wr && !full_s;
    rd_acc_s = rd && !empty_s;
  end

  // Storage array; intentionally not reset, contents are discarded logically.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at fifo_depth because it is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {aw{1'b0}};
      rd_ptr_r <= {aw{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + aw'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + aw'(1);
      end
    end
  end

  // Occupancy: a simultaneous accepted write and read leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {cw{1'b0}};
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + cw'(1);
        2'b01:   count_r <= count_r - cw'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Rejection pulses: high the cycle after each rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= wr && full_s;
      underflow_r <= rd && empty_s;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; valid follows occupancy (0 in reset).
  always_comb begin
    rdata = mem_r[rd_ptr_r];
    valid = !empty_s;
  end
`else
  logic [data_width-1:0] rdata_r;
  logic                  valid_r;

  // Registered read port: capture head word on accept, hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {data_width{1'b0}};
      valid_r <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        rdata_r <= mem_r[rd_ptr_r];
        valid_r <= 1'b1;
      end else begin
        rdata_r <= rdata_r;
        valid_r <= 1'b0;
      end
    end
  end

  // Drive read outputs from the registered read port.
  always_comb begin
    rdata = rdata_r;
    valid = valid_r;
  end
`endif

  // Output mapping.
  always_comb begin
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_r >= afull_c);
    almost_empty = (count_r <= aempty_c);
    count        = count_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule
